// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: shared types and encodings for the multi-cycle MIPS core.
// Holds the FSM state enum, the ALU operation enum and the opcode/funct
// encodings recognised by the decoder.
package mips_mc_pkg;

    typedef enum logic [1:0] {
        FETCH,
        DECODE,
        EXECUTE,
        WRITEBACK
    } state_t;

    typedef enum logic [2:0] {
        ADD,
        SUB,
        AND,
        OR,
        SLT,
        SLTU,
        SLL,
        SRL
    } alu_op_t;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

endpackage

// File: rtl/mips_mc_alu.sv
// mips_mc_alu: combinational ALU shared by every instruction class.
// Configuration macro: MIPS_MC_SHIFT_EN (when undefined no shifter is built).
// Ports:
//   a, b    DATA_W operands (b is the shift source)
//   shamt   5-bit shift amount
//   alu_op  operation select
//   y       DATA_W result
module mips_mc_alu
    import mips_mc_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [4:0]        shamt,
    input  alu_op_t           alu_op,
    output logic [DATA_W-1:0] y
);

    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;

    assign a_s = a;
    assign b_s = b;

`ifndef MIPS_MC_SHIFT_EN
    logic unused_shamt;
    assign unused_shamt = ^shamt;
`endif

    always_comb begin
        y = '0;
        case (alu_op)
            ADD:  y = a + b;
            SUB:  y = a - b;
            AND:  y = a & b;
            OR:   y = a | b;
            SLT:  y = DATA_W'(a_s < b_s);
            SLTU: y = DATA_W'(a < b);
`ifdef MIPS_MC_SHIFT_EN
            SLL:  y = b << shamt;
            SRL:  y = b >> shamt;
`endif
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/mips_multi_cycle.sv
// mips_multi_cycle: multi-cycle MIPS-style integer core.
// Each instruction walks FETCH -> DECODE -> EXECUTE -> WRITEBACK; branches,
// jumps and illegal encodings return to FETCH straight from EXECUTE.
// Configuration macro: MIPS_MC_SHIFT_EN enables sll/srl.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_req/imem_addr  fetch request and address (address == pc)
//   imem_valid/data     fetch response
//   pc                  current program counter
//   result/result_valid registered write-back value and one-cycle strobe
//   illegal             one-cycle pulse after an unsupported encoding
module mips_multi_cycle
    import mips_mc_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter int          NREGS    = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_valid,
    input  logic [31:0]       imem_data,
    output logic [31:0]       pc,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              illegal
);

    localparam int RW = $clog2(NREGS);

    state_t            state;
    state_t            next_state;
    logic [31:0]       ir;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] alu_y;
    logic [DATA_W-1:0] regs [NREGS];

    logic [5:0]    opcode;
    logic [5:0]    funct;
    logic [RW-1:0] rs_idx;
    logic [RW-1:0] rt_idx;
    logic [RW-1:0] rd_idx;
    logic [RW-1:0] wr_idx;
    logic [31:0]   pc_plus4;
    logic [31:0]   br_target;

    alu_op_t alu_op;
    logic    use_imm;
    logic    is_legal;
    logic    is_beq;
    logic    is_j;

    assign opcode    = ir[31:26];
    assign funct     = ir[5:0];
    assign rs_idx    = ir[21 +: RW];
    assign rt_idx    = ir[16 +: RW];
    assign rd_idx    = ir[11 +: RW];
    assign wr_idx    = (opcode == OP_RTYPE) ? rd_idx : rt_idx;
    assign pc_plus4  = pc + 32'd4;
    assign br_target = pc_plus4 + (32'($signed(ir[15:0])) << 2);

    // Instruction classification, valid once IR is loaded
    always_comb begin
        alu_op   = ADD;
        use_imm  = 1'b0;
        is_legal = 1'b0;
        is_beq   = 1'b0;
        is_j     = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  begin is_legal = 1'b1; alu_op = ADD;  end
                    FN_SUB:  begin is_legal = 1'b1; alu_op = SUB;  end
                    FN_AND:  begin is_legal = 1'b1; alu_op = AND;  end
                    FN_OR:   begin is_legal = 1'b1; alu_op = OR;   end
                    FN_SLT:  begin is_legal = 1'b1; alu_op = SLT;  end
                    FN_SLTU: begin is_legal = 1'b1; alu_op = SLTU; end
`ifdef MIPS_MC_SHIFT_EN
                    FN_SLL:  begin is_legal = 1'b1; alu_op = SLL;  end
                    FN_SRL:  begin is_legal = 1'b1; alu_op = SRL;  end
`endif
                    default: is_legal = 1'b0;
                endcase
            end
            OP_ADDI:  begin is_legal = 1'b1; use_imm = 1'b1; alu_op = ADD;  end
            OP_SLTI:  begin is_legal = 1'b1; use_imm = 1'b1; alu_op = SLT;  end
            OP_SLTIU: begin is_legal = 1'b1; use_imm = 1'b1; alu_op = SLTU; end
            OP_ANDI:  begin is_legal = 1'b1; use_imm = 1'b1; alu_op = AND;  end
            OP_ORI:   begin is_legal = 1'b1; use_imm = 1'b1; alu_op = OR;   end
            OP_BEQ:   begin is_legal = 1'b1; is_beq = 1'b1; end
            OP_J:     begin is_legal = 1'b1; is_j = 1'b1;   end
            default:  is_legal = 1'b0;
        endcase
    end

    mips_mc_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a      (a),
        .b      (use_imm ? imm : b),
        .shamt  (ir[10:6]),
        .alu_op (alu_op),
        .y      (alu_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        imem_req   = 1'b0;
        imem_addr  = pc;
        case (state)
            FETCH: begin
                imem_req = rst_n;
                if (imem_valid) next_state = DECODE;
            end
            DECODE:  next_state = EXECUTE;
            EXECUTE: next_state = (!is_legal || is_beq || is_j) ? FETCH : WRITEBACK;
            WRITEBACK: next_state = FETCH;
            default: next_state = FETCH;
        endcase
    end

    // Datapath latches: IR in FETCH, operands in DECODE, ALU result in EXECUTE
    always_ff @(posedge clk) begin
        if (state == FETCH && imem_valid) ir <= imem_data;
        if (state == DECODE) begin
            a   <= (rs_idx == '0) ? '0 : regs[rs_idx];
            b   <= (rt_idx == '0) ? '0 : regs[rt_idx];
            imm <= (opcode == OP_ANDI || opcode == OP_ORI) ? DATA_W'(ir[15:0])
                                                           : DATA_W'($signed(ir[15:0]));
        end
        if (state == EXECUTE) alu_out <= alu_y;
    end

    // Architectural state: PC, register file and reported outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            result       <= '0;
            result_valid <= 1'b0;
            illegal      <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            result_valid <= 1'b0;
            illegal      <= 1'b0;
            if (state == EXECUTE) begin
                if (!is_legal) begin
                    illegal <= 1'b1;
                    pc      <= pc_plus4;
                end else if (is_beq) begin
                    pc <= (a == b) ? br_target : pc_plus4;
                end else if (is_j) begin
                    pc <= {pc_plus4[31:28], ir[25:0], 2'b00};
                end
            end
            if (state == WRITEBACK) begin
                if (wr_idx != '0) regs[wr_idx] <= alu_out;
                result       <= alu_out;
                result_valid <= 1'b1;
                pc           <= pc_plus4;
            end
        end
    end

endmodule

// File: tb/tb_mips_multi_cycle.sv
module tb_mips_multi_cycle;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_valid;
    logic [31:0] imem_data;

    logic        imem_req, result_valid, illegal;
    logic [31:0] imem_addr, pc, result;
    logic        imem_req2, result_valid2, illegal2;
    logic [31:0] imem_addr2, pc2;
    logic [15:0] result2;

    int n_checks = 0;
    int n_fails  = 0;

    logic        saw_rv, saw_ill, fin_rv, fin_ill;
    logic [31:0] fin_res;
    logic [15:0] fin_res2;

    always #5 clk = ~clk;

    mips_multi_cycle #(.DATA_W(32), .NREGS(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_data(imem_data), .pc(pc), .result(result),
        .result_valid(result_valid), .illegal(illegal)
    );

    // Narrow core at a high reset PC, fed the same instruction stream in lockstep
    mips_multi_cycle #(.DATA_W(16), .NREGS(32), .RESET_PC(32'h1000_0000)) dut2 (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_valid(imem_valid), .imem_data(imem_data), .pc(pc2), .result(result2),
        .result_valid(result_valid2), .illegal(illegal2)
    );

    // Called at a negedge in FETCH: presents one instruction, runs to next FETCH
    task automatic fetch_one(input logic [31:0] instr, output int cycles);
        int k;
        cycles  = 1;
        saw_rv  = 1'b0;
        saw_ill = 1'b0;
        imem_valid = 1'b1;
        imem_data  = instr;
        @(negedge clk);
        imem_valid = 1'b0;
        imem_data  = 32'h0;
        k = 0;
        while (imem_req !== 1'b1 && k < 20) begin
            saw_rv  = saw_rv | result_valid | result_valid2;
            saw_ill = saw_ill | illegal;
            @(negedge clk);
            k++;
            cycles++;
        end
        n_checks++;
        if (k >= 20) begin
            n_fails++;
            $display("FAIL fetch_timeout: instr %h got no FETCH within %0d cycles, required < 20", instr, k);
        end
        fin_rv   = result_valid;
        fin_ill  = illegal;
        fin_res  = result;
        fin_res2 = result2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_valid = 1'b0; imem_data = 32'h0;
        repeat (3) @(negedge clk);
        n_checks++; if (imem_req !== 1'b0) begin n_fails++; $display("FAIL rst_req: got %b required 0", imem_req); end
        n_checks++; if (pc !== 32'h0) begin n_fails++; $display("FAIL rst_pc: got %h required 0", pc); end
        n_checks++; if (pc2 !== 32'h1000_0000) begin n_fails++; $display("FAIL rst_pc2: got %h required 10000000", pc2); end
        n_checks++; if (result !== 32'h0 || result_valid !== 1'b0 || illegal !== 1'b0) begin
            n_fails++; $display("FAIL rst_outs: got res %h rv %b ill %b required 0/0/0", result, result_valid, illegal); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fails++; $display("FAIL rel_fetch: got req %b addr %h required 1/00000000", imem_req, imem_addr); end
        n_checks++; if (imem_req2 !== 1'b1 || imem_addr2 !== 32'h1000_0000) begin
            n_fails++; $display("FAIL rel_fetch2: got req %b addr %h required 1/10000000", imem_req2, imem_addr2); end
    endtask

    task automatic test_alu_seq();
        int c;
        fetch_one(32'h2001_FFFF, c);   // addi r1,r0,-1
        n_checks++; if (c != 4) begin n_fails++; $display("FAIL addi_cycles: got %0d required 4", c); end
        n_checks++; if (saw_rv !== 1'b0) begin n_fails++; $display("FAIL addi_early_rv: got %b required 0", saw_rv); end
        n_checks++; if (fin_rv !== 1'b1 || fin_res !== 32'hFFFF_FFFF) begin
            n_fails++; $display("FAIL addi_res: got rv %b res %h required 1/ffffffff", fin_rv, fin_res); end
        n_checks++; if (fin_res2 !== 16'hFFFF) begin n_fails++; $display("FAIL addi_res16: got %h required ffff", fin_res2); end
        n_checks++; if (pc !== 32'h4 || imem_addr !== 32'h4) begin
            n_fails++; $display("FAIL addi_pc: got pc %h addr %h required 4/4", pc, imem_addr); end
        fetch_one(32'h0001_102B, c);   // sltu r2,r0,r1
        n_checks++; if (fin_rv !== 1'b1 || fin_res !== 32'h1 || fin_res2 !== 16'h1) begin
            n_fails++; $display("FAIL sltu_res: got rv %b res %h res16 %h required 1/1/1", fin_rv, fin_res, fin_res2); end
        fetch_one(32'h0001_182A, c);   // slt r3,r0,r1
        n_checks++; if (fin_rv !== 1'b1 || fin_res !== 32'h0 || fin_res2 !== 16'h0) begin
            n_fails++; $display("FAIL slt_res: got rv %b res %h res16 %h required 1/0/0", fin_rv, fin_res, fin_res2); end
        n_checks++; if (pc !== 32'hC) begin n_fails++; $display("FAIL seq_pc: got %h required c", pc); end
    endtask

    task automatic test_r0();
        int c;
        fetch_one(32'h2000_0007, c);   // addi r0,r0,7
        n_checks++; if (fin_rv !== 1'b1 || fin_res !== 32'h7) begin
            n_fails++; $display("FAIL r0_write_res: got rv %b res %h required 1/7", fin_rv, fin_res); end
        fetch_one(32'h0000_2025, c);   // or r4,r0,r0
        n_checks++; if (fin_rv !== 1'b1 || fin_res !== 32'h0) begin
            n_fails++; $display("FAIL r0_reads_zero: got rv %b res %h required 1/0", fin_rv, fin_res); end
    endtask

    task automatic test_wait();
        int c;
        imem_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin
                n_fails++; $display("FAIL wait_hold%0d: got req %b addr %h required 1/14", i, imem_req, imem_addr); end
            @(negedge clk);
        end
        fetch_one(32'h2005_0012, c);   // addi r5,r0,0x12
        n_checks++; if (c + 5 != 9) begin n_fails++; $display("FAIL wait_latency: got %0d required 9", c + 5); end
        n_checks++; if (fin_res !== 32'h12) begin n_fails++; $display("FAIL wait_res: got %h required 12", fin_res); end
    endtask

    task automatic test_imm_ext();
        int c;
        fetch_one(32'h3407_8000, c);   // ori r7,r0,0x8000
        n_checks++; if (fin_res !== 32'h0000_8000 || fin_res2 !== 16'h8000) begin
            n_fails++; $display("FAIL ori_zext: got %h/%h required 00008000/8000", fin_res, fin_res2); end
        fetch_one(32'h3028_FFFF, c);   // andi r8,r1,0xFFFF
        n_checks++; if (fin_res !== 32'h0000_FFFF || fin_res2 !== 16'hFFFF) begin
            n_fails++; $display("FAIL andi_zext: got %h/%h required 0000ffff/ffff", fin_res, fin_res2); end
    endtask

    task automatic test_illegal();
        int c;
        fetch_one(32'hFC00_0000, c);   // opcode 0x3F
        n_checks++; if (c != 3) begin n_fails++; $display("FAIL ill_cycles: got %0d required 3", c); end
        n_checks++; if (fin_ill !== 1'b1 || saw_ill !== 1'b0) begin
            n_fails++; $display("FAIL ill_pulse: got fin %b early %b required 1/0", fin_ill, saw_ill); end
        n_checks++; if (fin_rv !== 1'b0 || saw_rv !== 1'b0) begin
            n_fails++; $display("FAIL ill_no_rv: got %b/%b required 0/0", fin_rv, saw_rv); end
        n_checks++; if (pc !== 32'h24) begin n_fails++; $display("FAIL ill_pc: got %h required 24", pc); end
        @(negedge clk);
        n_checks++; if (illegal !== 1'b0) begin n_fails++; $display("FAIL ill_once: got %b required 0", illegal); end
    endtask

    task automatic test_shift();
        int c;
        fetch_one(32'h2002_0005, c);   // addi r2,r0,5
        n_checks++; if (fin_res !== 32'h5) begin n_fails++; $display("FAIL shift_setup: got %h required 5", fin_res); end
        fetch_one(32'h0002_08C0, c);   // sll r1,r2,3
`ifdef MIPS_MC_SHIFT_EN
        n_checks++; if (c != 4 || fin_rv !== 1'b1 || fin_res !== 32'd40 || fin_res2 !== 16'd40) begin
            n_fails++; $display("FAIL sll_res: got cyc %0d rv %b res %h/%h required 4/1/28/28", c, fin_rv, fin_res, fin_res2); end
`else
        n_checks++; if (c != 3 || fin_ill !== 1'b1 || fin_rv !== 1'b0) begin
            n_fails++; $display("FAIL sll_illegal: got cyc %0d ill %b rv %b required 3/1/0", c, fin_ill, fin_rv); end
`endif
        n_checks++; if (pc !== 32'h2C) begin n_fails++; $display("FAIL shift_pc: got %h required 2c", pc); end
    endtask

    task automatic test_branch();
        int c;
        fetch_one(32'h0800_0040, c);   // j 0x40
        n_checks++; if (c != 3 || saw_rv !== 1'b0 || fin_rv !== 1'b0) begin
            n_fails++; $display("FAIL j_timing: got cyc %0d rv %b/%b required 3/0/0", c, saw_rv, fin_rv); end
        n_checks++; if (imem_addr !== 32'h100) begin n_fails++; $display("FAIL j_addr: got %h required 100", imem_addr); end
        n_checks++; if (imem_addr2 !== 32'h1000_0100) begin
            n_fails++; $display("FAIL j_addr_hi: got %h required 10000100", imem_addr2); end
        fetch_one(32'h1000_FFFF, c);   // beq r0,r0,-1
        n_checks++; if (c != 3 || fin_rv !== 1'b0 || imem_addr !== 32'h100) begin
            n_fails++; $display("FAIL beq_taken: got cyc %0d rv %b addr %h required 3/0/100", c, fin_rv, imem_addr); end
        fetch_one(32'h1001_0005, c);   // beq r0,r1,5 (not taken)
        n_checks++; if (pc !== 32'h104 || pc2 !== 32'h1000_0104) begin
            n_fails++; $display("FAIL beq_not_taken: got %h/%h required 104/10000104", pc, pc2); end
    endtask

    task automatic test_reset_mid();
        int c;
        imem_valid = 1'b1;
        imem_data  = 32'h2009_0003;    // addi r9,r0,3
        @(negedge clk);
        imem_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);                // in WRITEBACK now
        rst_n = 1'b0;
        #1;
        n_checks++; if (pc !== 32'h0 || imem_req !== 1'b0) begin
            n_fails++; $display("FAIL mid_rst_pc: got pc %h req %b required 0/0", pc, imem_req); end
        n_checks++; if (result !== 32'h0 || result_valid !== 1'b0) begin
            n_fails++; $display("FAIL mid_rst_res: got %h rv %b required 0/0", result, result_valid); end
        @(negedge clk);
        n_checks++; if (result_valid !== 1'b0) begin n_fails++; $display("FAIL mid_rst_nowb: got %b required 0", result_valid); end
        rst_n = 1'b1;
        #1;
        fetch_one(32'h0120_5025, c);   // or r10,r9,r0
        n_checks++; if (c != 4 || fin_res !== 32'h0) begin
            n_fails++; $display("FAIL mid_rst_after: got cyc %0d res %h required 4/0", c, fin_res); end
    endtask

    initial begin
        test_reset();
        test_alu_seq();
        test_r0();
        test_wait();
        test_imm_ext();
        test_illegal();
        test_shift();
        test_branch();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
